// File: rtl/mips_pkg.sv
// Shared multiply/divide definitions: operation encodings, FSM states, iteration count.
package mips_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CALC,
    FIX
  } md_state_t;

  localparam int unsigned MD_ITER = 32;

endpackage

// File: rtl/muldiv_unit_if.sv
// Core-to-muldiv bundle: launch, operands, mthi/mtlo writes and HI/LO readback.
interface muldiv_unit_if;
  import mips_pkg::*;

  logic        start;
  muldiv_op_t  op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        hi_wr;
  logic        lo_wr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, op_a, op_b, hi_wr, lo_wr, wr_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, op_a, op_b, hi_wr, lo_wr, wr_data,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_unit_abs32.sv
// Magnitude/sign split of a 32-bit value; treated as unsigned when i_signed is low.
module abs32 (
  input  logic [31:0] i_val,
  input  logic        i_signed,
  output logic [31:0] o_mag,
  output logic        o_neg
);

  assign o_neg = i_signed & i_val[31];
  // 0x8000_0000 maps to itself, which is the correct unsigned magnitude.
  assign o_mag = o_neg ? (~i_val + 32'd1) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide with architectural HI/LO; fixed 35-cycle latency.
module muldiv_unit
  import mips_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  muldiv_unit_if.slave  io_md
);

  md_state_t   r_state;
  md_state_t   w_state_next;
  muldiv_op_t  r_op;
  logic [4:0]  r_cnt;
  logic [31:0] r_a;    // multiplicand / dividend magnitude (held constant)
  logic [31:0] r_b;    // multiplier (shifted out) / divisor magnitude
  logic        r_sa;
  logic        r_sb;
  logic        r_dz;
  logic [63:0] r_acc;  // multiply: product; divide: {rem, quot}
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_ld_signed;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_a_neg;
  logic        w_b_neg;
  logic        w_op_signed;
  logic [32:0] w_mul_sum;
  logic [32:0] w_div_sh;
  logic [33:0] w_div_diff;
  logic        w_qbit;
  logic [31:0] w_div_rem;
  logic [63:0] w_prod;
  logic [31:0] w_quot_fix;
  logic [31:0] w_rem_fix;
  logic [31:0] w_orig_a;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  // op encodings 00/10 are the signed variants
  assign w_ld_signed = ~io_md.op[0];
  assign w_op_signed = ~r_op[0];

  abs32 u_abs_a (
    .i_val    (io_md.op_a),
    .i_signed (w_ld_signed),
    .o_mag    (w_a_mag),
    .o_neg    (w_a_neg)
  );

  abs32 u_abs_b (
    .i_val    (io_md.op_b),
    .i_signed (w_ld_signed),
    .o_mag    (w_b_mag),
    .o_neg    (w_b_neg)
  );

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (io_md.start) w_state_next = LOAD;
      LOAD:    w_state_next = CALC;
      CALC:    if (r_cnt == 5'd0) w_state_next = FIX;
      FIX:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // One shift-add / restoring-divide step and the final sign fix-up
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[63:32]} + (r_b[0] ? {1'b0, r_a} : 33'd0);
    // dividend bits are consumed MSB first, indexed by the down-counter
    w_div_sh   = {r_acc[63:32], r_a[r_cnt]};
    w_div_diff = {1'b0, w_div_sh} - {2'b00, r_b};
    w_qbit     = ~w_div_diff[33];
    w_div_rem  = w_qbit ? w_div_diff[31:0] : w_div_sh[31:0];

    w_prod     = (w_op_signed && (r_sa ^ r_sb)) ? (~r_acc + 64'd1) : r_acc;
    w_quot_fix = (w_op_signed && (r_sa ^ r_sb)) ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
    w_rem_fix  = (w_op_signed && r_sa) ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
    w_orig_a   = (w_op_signed && r_sa) ? (~r_a + 32'd1) : r_a;

    w_res_hi = w_prod[63:32];
    w_res_lo = w_prod[31:0];
    if (r_op[1]) begin
      if (r_dz) begin
        w_res_hi = w_orig_a;
        w_res_lo = 32'hFFFF_FFFF;
      end else begin
        w_res_hi = w_rem_fix;
        w_res_lo = w_quot_fix;
      end
    end
  end

  // Control state, completion pulse and architectural HI/LO
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_state_next;
      r_done  <= (r_state == FIX);
      if (r_state == FIX) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else if (r_state == IDLE) begin
        if (io_md.hi_wr) r_hi <= io_md.wr_data;
        if (io_md.lo_wr) r_lo <= io_md.wr_data;
      end
    end
  end

  // Operand capture and iterative datapath; no reset needed, always reloaded in LOAD
  always_ff @(posedge i_clk) begin
    unique case (r_state)
      LOAD: begin
        r_op  <= io_md.op;
        r_a   <= w_a_mag;
        r_b   <= w_b_mag;
        r_sa  <= w_a_neg;
        r_sb  <= w_b_neg;
        r_dz  <= (w_b_mag == 32'd0);
        r_acc <= 64'd0;
        r_cnt <= 5'(MD_ITER - 1);
      end
      CALC: begin
        r_cnt <= r_cnt - 5'd1;
        if (r_op[1]) begin
          r_acc <= {w_div_rem, r_acc[30:0], w_qbit};
        end else begin
          r_acc <= {w_mul_sum, r_acc[31:1]};
          r_b   <= r_b >> 1;
        end
      end
      default: ;
    endcase
  end

  assign io_md.busy = (r_state != IDLE);
  assign io_md.done = r_done;
  assign io_md.hi   = r_hi;
  assign io_md.lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_unit_if u_if ();

  muldiv_unit u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_md (u_if.slave)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference: MIPS semantics from plain 64-bit / integer arithmetic
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    longint      sp;
    logic [63:0] up;
    int          sa;
    int          sb;
    sa = int'(a);
    sb = int'(b);
    case (op)
      2'b00: begin
        sp = longint'(sa) * longint'(sb);
        {h, l} = sp;
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        {h, l} = up;
      end
      2'b10: begin
        if (b == 32'd0) begin
          l = 32'hFFFF_FFFF; h = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          l = 32'h8000_0000; h = 32'd0;
        end else begin
          l = sa / sb; h = sa % sb;
        end
      end
      default: begin
        if (b == 32'd0) begin
          l = 32'hFFFF_FFFF; h = a;
        end else begin
          l = a / b; h = a % b;
        end
      end
    endcase
  endfunction

  function automatic logic [31:0] rnd_val();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'd0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      3:       v = 32'($urandom_range(0, 20));
      4:       v = -32'($urandom_range(1, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // mode 0: plain; 1: start/hi_wr/operand churn while busy; 2: reset at cycle 20
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int mode);
    logic [31:0] exp_hi, exp_lo, hi0, lo0;
    int          done_cyc, busy_bad, stable_bad, last;
    logic        busy_exp;
    model(op, a, b, exp_hi, exp_lo);
    hi0 = u_if.hi;
    lo0 = u_if.lo;
    u_if.op    = muldiv_op_t'(op);
    u_if.op_a  = a;
    u_if.op_b  = b;
    u_if.start = 1'b1;
    @(posedge clk);
    #1;
    u_if.start = 1'b0;
    done_cyc = -1; busy_bad = 0; stable_bad = 0;
    last = (mode == 2) ? 40 : 35;
    for (int c = 1; c <= last; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (mode == 1) begin
        if (c == 2) begin
          u_if.op   = muldiv_op_t'(2'($urandom));
          u_if.op_a = $urandom;
          u_if.op_b = $urandom;
        end
        if (c == 10) begin
          u_if.start = 1'b1;
          u_if.op_a  = 32'd77;
          u_if.op_b  = 32'd3;
        end
        if (c == 11) u_if.start = 1'b0;
        if (c == 12) begin
          u_if.hi_wr   = 1'b1;
          u_if.wr_data = 32'h1234;
        end
        if (c == 13) u_if.hi_wr = 1'b0;
      end
      if (mode == 2 && c == 20) rst = 1'b1;
      if (mode == 2 && c == 21) rst = 1'b0;
      @(negedge clk);
      busy_exp = (mode == 2 && c >= 21) ? 1'b0 : (c <= 34);
      if (u_if.busy !== busy_exp) busy_bad++;
      if (u_if.done === 1'b1 && done_cyc < 0) done_cyc = c;
      if (c < 35 && !(mode == 2 && c >= 21) && (u_if.hi !== hi0 || u_if.lo !== lo0))
        stable_bad++;
      if (mode == 2 && c == 21) begin
        check_eq("rst_hi", u_if.hi, 32'd0);
        check_eq("rst_lo", u_if.lo, 32'd0);
      end
    end
    check_eq("busy_profile", busy_bad, 0);
    check_eq("hilo_stable", stable_bad, 0);
    if (mode == 2) begin
      check_eq("no_done_after_rst", done_cyc, -1);
    end else begin
      check_eq("done_cycle", done_cyc, 35);
      check_eq("hi", u_if.hi, exp_hi);
      check_eq("lo", u_if.lo, exp_lo);
    end
  endtask

  initial begin
    u_if.start   = 1'b0;
    u_if.op      = MD_MULT;
    u_if.op_a    = 32'd0;
    u_if.op_b    = 32'd0;
    u_if.hi_wr   = 1'b0;
    u_if.lo_wr   = 1'b0;
    u_if.wr_data = 32'd0;
    rst          = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_busy", u_if.busy, 1'b0);
    check_eq("reset_done", u_if.done, 1'b0);
    check_eq("reset_hi", u_if.hi, 32'd0);
    check_eq("reset_lo", u_if.lo, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(2'b00, -32'd3, 32'd5, 0);
    do_op(2'b10, -32'd7, 32'd2, 0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(2'b11, 32'd100, 32'd0, 0);
    do_op(2'b00, 32'h0001_2345, 32'hFFFF_0007, 1);
    do_op(2'b11, 32'hDEAD_BEEF, 32'd9, 1);

    // mthi in IDLE lands on the next edge, LO untouched
    begin
      logic [31:0] lo_keep;
      lo_keep = u_if.lo;
      u_if.hi_wr   = 1'b1;
      u_if.wr_data = 32'h1234;
      @(posedge clk);
      #1;
      u_if.hi_wr = 1'b0;
      check_eq("mthi_hi", u_if.hi, 32'h1234);
      check_eq("mthi_lo", u_if.lo, lo_keep);
      u_if.hi_wr   = 1'b1;
      u_if.lo_wr   = 1'b1;
      u_if.wr_data = 32'hCAFE_0042;
      @(posedge clk);
      #1;
      u_if.hi_wr = 1'b0;
      u_if.lo_wr = 1'b0;
      check_eq("both_wr_hi", u_if.hi, 32'hCAFE_0042);
      check_eq("both_wr_lo", u_if.lo, 32'hCAFE_0042);
    end

    do_op(2'b10, 32'd1000, 32'd7, 2);
    @(posedge clk);
    #1;

    for (int i = 0; i < 40; i++) begin
      do_op(2'($urandom), rnd_val(), rnd_val(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
